// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for Datapath_P2.
// Steps each instruction through fetch (T0-T2) and execute (T3-T6),
// decoding datapath strobes from the current step and IR[31:27].
module control_sequencer #(
    parameter int OPW      = 5,
    parameter int MEM_WAIT = 0
) (
    input  logic           Clock,
    input  logic           Clear,
    input  logic [31:0]    IR,
    input  logic           Stop,
    // bus-drive strobes
    output logic           PCout,
    output logic           Zhiout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           HIout,
    output logic           LOout,
    output logic           InPortout,
    output logic           Cout,
    // register-load strobes
    output logic           MARin,
    output logic           Zin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           HIin,
    output logic           LOin,
    output logic           OutPortin,
    // misc datapath controls
    output logic           IncPC,
    output logic           Read,
    output logic           Write,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAout,
    output logic           CONin,
    output logic [OPW-1:0] alu_op,
    output logic           Run,
    output logic           illegal
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10101);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10110);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b10111);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11000);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11001);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11010);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_t         state;
    logic [3:0]     wait_cnt;
    logic [OPW-1:0] opcode;
    logic           is_reg_alu;
    logic           is_imm_alu;
    logic           is_muldiv;
    logic           is_halt;
    logic [OPW-1:0] imm_op;
    logic           unused_ir;

    assign opcode    = IR[31 -: OPW];
    assign unused_ir = ^IR[31-OPW:0];

    // Instruction class decode; selects the length of the execute phase.
    always_comb begin
        is_reg_alu = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
        is_imm_alu = opcode inside {OP_ADDI, OP_ANDI, OP_ORI};
        is_muldiv  = opcode inside {OP_MUL, OP_DIV};
        is_halt    = (opcode == OP_HALT);
        imm_op     = '0;
        case (opcode)
            OP_ADDI: imm_op = OP_ADD;
            OP_ANDI: imm_op = OP_AND;
            OP_ORI:  imm_op = OP_OR;
            default: imm_op = '0;
        endcase
    end

    // Step sequencer: Clear wins over everything; Stop only matters on the
    // edge that leaves the final execute step of an instruction.
    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state    <= S_RST;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_RST:  state <= S_T0;
                S_T0: begin
                    state    <= S_T1;
                    wait_cnt <= WAIT_INIT;
                end
                S_T1: begin
                    // count down memory wait cycles; saturates at zero
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                    else                  state    <= S_T2;
                end
                S_T2:   state <= S_T3;
                S_T3: begin
                    if (is_reg_alu || is_imm_alu || is_muldiv) state <= S_T4;
                    else if (is_halt)                          state <= S_HALT;
                    else                                       state <= Stop ? S_HALT : S_T0;
                end
                S_T4:   state <= S_T5;
                S_T5: begin
                    if (is_muldiv) state <= S_T6;
                    else           state <= Stop ? S_HALT : S_T0;
                end
                S_T6:   state <= Stop ? S_HALT : S_T0;
                S_HALT: state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    // Strobe decode from the registered step and the opcode. IR is only
    // loaded at the T2->T3 edge, so execute strobes cannot be precomputed a
    // cycle early; they depend on state and IR only, never on Stop.
    always_comb begin
        PCout = 1'b0; Zhiout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        Rin = 1'b0; Rout = 1'b0;
        alu_op  = '0;
        illegal = 1'b0;
        Run     = (state != S_HALT);
        case (state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                // incremented PC is latched once, on the final wait cycle
                PCin    = (wait_cnt == 4'd0);
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    OP_MFHI: begin Gra = 1'b1; Rin = 1'b1; HIout = 1'b1; end
                    OP_MFLO: begin Gra = 1'b1; Rin = 1'b1; LOout = 1'b1; end
                    OP_IN:   begin Gra = 1'b1; Rin = 1'b1; InPortout = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    OP_NOP, OP_HALT: ;
                    default: illegal = 1'b1;
                endcase
            end
            S_T4: begin
                if (is_reg_alu) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
                end else if (is_imm_alu) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = imm_op;
                end else if (is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) LOin = 1'b1;
                else begin Gra = 1'b1; Rin = 1'b1; end
            end
            S_T6: begin
                Zhiout = 1'b1; HIin = 1'b1;
            end
            default: ;
        endcase
    end

    // Memory-write, base-address and condition controls are held low.
    assign Write = 1'b0;
    assign BAout = 1'b0;
    assign CONin = 1'b0;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a step-list model builds the expected output
// vector for every cycle of each instruction; one negedge process compares.
module tb_control_sequencer;

    typedef struct packed {
        logic pcout, zhiout, zlowout, mdrout, hiout, loout, inportout, cout;
        logic marin, zin, pcin, mdrin, irin, yin, hiin, loin, outportin;
        logic incpc, read, write, gra, grb, grc, rin, rout, baout, conin;
        logic [4:0] alu_op;
        logic run, illegal;
    } outv_t;

    logic        Clock = 1'b0;
    logic        Clear0, Clear2, Stop0, Stop2;
    logic [31:0] IR0, IR2;
    logic [33:0] r0, r2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    outv_t q0[$];
    outv_t q2[$];
    outv_t seq[$];
    outv_t e0, e2;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    control_sequencer #(.OPW(5), .MEM_WAIT(0)) dut0 (
        .Clock(Clock), .Clear(Clear0), .IR(IR0), .Stop(Stop0),
        .PCout(r0[33]), .Zhiout(r0[32]), .Zlowout(r0[31]), .MDRout(r0[30]),
        .HIout(r0[29]), .LOout(r0[28]), .InPortout(r0[27]), .Cout(r0[26]),
        .MARin(r0[25]), .Zin(r0[24]), .PCin(r0[23]), .MDRin(r0[22]), .IRin(r0[21]),
        .Yin(r0[20]), .HIin(r0[19]), .LOin(r0[18]), .OutPortin(r0[17]),
        .IncPC(r0[16]), .Read(r0[15]), .Write(r0[14]), .Gra(r0[13]), .Grb(r0[12]),
        .Grc(r0[11]), .Rin(r0[10]), .Rout(r0[9]), .BAout(r0[8]), .CONin(r0[7]),
        .alu_op(r0[6:2]), .Run(r0[1]), .illegal(r0[0])
    );

    control_sequencer #(.OPW(5), .MEM_WAIT(2)) dut2 (
        .Clock(Clock), .Clear(Clear2), .IR(IR2), .Stop(Stop2),
        .PCout(r2[33]), .Zhiout(r2[32]), .Zlowout(r2[31]), .MDRout(r2[30]),
        .HIout(r2[29]), .LOout(r2[28]), .InPortout(r2[27]), .Cout(r2[26]),
        .MARin(r2[25]), .Zin(r2[24]), .PCin(r2[23]), .MDRin(r2[22]), .IRin(r2[21]),
        .Yin(r2[20]), .HIin(r2[19]), .LOin(r2[18]), .OutPortin(r2[17]),
        .IncPC(r2[16]), .Read(r2[15]), .Write(r2[14]), .Gra(r2[13]), .Grb(r2[12]),
        .Grc(r2[11]), .Rin(r2[10]), .Rout(r2[9]), .BAout(r2[8]), .CONin(r2[7]),
        .alu_op(r2[6:2]), .Run(r2[1]), .illegal(r2[0])
    );

    // ---------------- model ----------------
    function automatic outv_t running();
        outv_t v = '0;
        v.run = 1'b1;
        return v;
    endfunction

    // Expected per-cycle outputs of one instruction, T0 to its last step.
    task automatic build_instr(input logic [4:0] op, input int mw);
        outv_t v;
        seq.delete();
        v = running(); v.pcout = 1; v.marin = 1; v.incpc = 1; v.zin = 1; seq.push_back(v);
        for (int i = 0; i <= mw; i++) begin
            v = running(); v.zlowout = 1; v.read = 1; v.mdrin = 1; v.pcin = (i == mw);
            seq.push_back(v);
        end
        v = running(); v.mdrout = 1; v.irin = 1; seq.push_back(v);
        case (op)
            5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101: begin
                v = running(); v.grb = 1; v.rout = 1; v.yin = 1; seq.push_back(v);
                v = running(); v.zin = 1;
                if (op == 5'b01011)      begin v.cout = 1; v.alu_op = 5'b00011; end
                else if (op == 5'b01100) begin v.cout = 1; v.alu_op = 5'b01001; end
                else if (op == 5'b01101) begin v.cout = 1; v.alu_op = 5'b01010; end
                else begin v.grc = 1; v.rout = 1; v.alu_op = op; end
                seq.push_back(v);
                v = running(); v.zlowout = 1; v.gra = 1; v.rin = 1; seq.push_back(v);
            end
            5'b01110, 5'b01111: begin
                v = running(); v.gra = 1; v.rout = 1; v.yin = 1; seq.push_back(v);
                v = running(); v.grb = 1; v.rout = 1; v.zin = 1; v.alu_op = op; seq.push_back(v);
                v = running(); v.zlowout = 1; v.loin = 1; seq.push_back(v);
                v = running(); v.zhiout = 1; v.hiin = 1; seq.push_back(v);
            end
            5'b10111: begin v = running(); v.gra = 1; v.rin = 1; v.hiout = 1; seq.push_back(v); end
            5'b11000: begin v = running(); v.gra = 1; v.rin = 1; v.loout = 1; seq.push_back(v); end
            5'b10101: begin v = running(); v.gra = 1; v.rin = 1; v.inportout = 1; seq.push_back(v); end
            5'b10110: begin v = running(); v.gra = 1; v.rout = 1; v.outportin = 1; seq.push_back(v); end
            5'b11001, 5'b11010: seq.push_back(running());
            default: begin v = running(); v.illegal = 1; seq.push_back(v); end
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Every cycle that has a queued expectation is compared.
    always @(negedge Clock) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            checks++;
            if (r0 !== 34'(e0)) begin
                errors++;
                $display("FAIL dut0 outputs cycle %0d: got %b want %b", cyc, r0, 34'(e0));
            end
        end
        if (q2.size() > 0) begin
            e2 = q2.pop_front();
            checks++;
            if (r2 !== 34'(e2)) begin
                errors++;
                $display("FAIL dut2 outputs cycle %0d: got %b want %b", cyc, r2, 34'(e2));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_one(input int w, input outv_t v);
        if (w == 0) q0.push_back(v); else q2.push_back(v);
    endtask

    task automatic set_ir(input int w, input logic [4:0] op);
        if (w == 0) IR0 = {op, 27'h5a5a5a5}; else IR2 = {op, 27'h2c3c4c5};
    endtask

    task automatic set_stop(input int w, input logic s);
        if (w == 0) Stop0 = s; else Stop2 = s;
    endtask

    task automatic set_clear(input int w, input logic c);
        if (w == 0) Clear0 = c; else Clear2 = c;
    endtask

    // Run the first k steps of an instruction (k=0 means all of it).
    task automatic instr_k(input int w, input logic [4:0] op, input int k, input bit stop_end);
        int n;
        build_instr(op, w);
        n = (k == 0) ? seq.size() : k;
        for (int i = 0; i < n; i++) push_one(w, seq[i]);
        tick();
        set_ir(w, op);
        repeat (n - 1) tick();
        if (stop_end) set_stop(w, 1'b1);
    endtask

    task automatic instr(input int w, input logic [4:0] op, input bit stop_end);
        instr_k(w, op, 0, stop_end);
    endtask

    task automatic halt_run(input int w, input int n);
        for (int i = 0; i < n; i++) push_one(w, outv_t'('0));
        tick();
        set_stop(w, 1'b0);
        repeat (n - 1) tick();
    endtask

    task automatic do_clear(input int w);
        push_one(w, running());
        set_clear(w, 1'b0);
        tick();
        set_clear(w, 1'b1);
    endtask

    logic [4:0] ops [16];

    initial begin
        Clear0 = 1'b0; Clear2 = 1'b0; Stop0 = 1'b0; Stop2 = 1'b0;
        IR0 = '0; IR2 = '0;
        ops = '{5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01011, 5'b01100,
                5'b01101, 5'b01110, 5'b10111, 5'b01111, 5'b11000, 5'b10101,
                5'b10110, 5'b11001, 5'b11111, 5'b00000};

        // pin the model with hand-derived values
        build_instr(5'b00011, 0);
        chk("model add length", 64'(seq.size()), 6);
        chk("model add T4 alu_op", 64'(seq[4].alu_op), 64'(5'b00011));
        chk("model add T5 gra+rin", 64'(seq[5].gra & seq[5].rin & seq[5].zlowout), 1);
        build_instr(5'b01110, 0);
        chk("model mul length", 64'(seq.size()), 7);
        chk("model mul T5 loin / T6 hiin", 64'({seq[5].loin, seq[6].hiin}), 64'(2'b11));
        build_instr(5'b10111, 0);
        chk("model mfhi length", 64'(seq.size()), 4);
        chk("model mfhi T3", 64'(seq[3].hiout & seq[3].gra & seq[3].rin), 1);
        build_instr(5'b00011, 2);
        chk("model wait2 length", 64'(seq.size()), 8);
        chk("model wait2 pcin", 64'({seq[1].pcin, seq[2].pcin, seq[3].pcin, seq[3].read}), 64'(4'b0011));
        build_instr(5'b11111, 0);
        chk("model illegal T3", 64'(seq[3].illegal), 1);

        // reset: Clear low for two edges, then T0
        tick();
        push_one(0, running());
        tick();
        push_one(0, running());
        Clear0 = 1'b1;
        chk("dut0 Run in RST", 64'(r0[1]), 1);
        chk("dut0 strobes in RST", 64'(r0[33:2]), 0);

        foreach (ops[i]) instr(0, ops[i], 1'b0);

        // halt opcode
        instr(0, 5'b11010, 1'b0);
        halt_run(0, 20);
        chk("dut0 Run after halt", 64'(r0[1]), 0);
        do_clear(0);
        chk("dut0 Run after clear from HALT", 64'(r0[1]), 1);

        // Stop at final step of add
        instr(0, 5'b00011, 1'b1);
        halt_run(0, 20);
        do_clear(0);

        // Stop held through a whole mul: only the last edge honours it
        set_stop(0, 1'b1);
        instr(0, 5'b01110, 1'b0);
        halt_run(0, 20);
        do_clear(0);

        // Stop at final step of a one-step execute
        instr(0, 5'b10111, 1'b1);
        halt_run(0, 5);
        do_clear(0);

        // Clear during T4 of div, then recover
        instr_k(0, 5'b01111, 5, 1'b0);
        do_clear(0);
        instr(0, 5'b11001, 1'b0);
        instr(0, 5'b01010, 1'b0);

        // MEM_WAIT=2 build
        push_one(2, running());
        Clear2 = 1'b1;
        instr(2, 5'b00011, 1'b0);
        instr(2, 5'b01110, 1'b0);
        instr(2, 5'b11111, 1'b0);
        instr(2, 5'b01101, 1'b1);
        halt_run(2, 3);

        tick();
        tick();
        chk("dut0 queue drained", 64'(q0.size()), 0);
        chk("dut2 queue drained", 64'(q2.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
